uart_ctrl: RTL and testbench

//  CPU-side controller for the UART rx/tx engines: decodes port_id I/O strobes, holds the

---
 rtl/uart_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// CPU-side UART controller: I/O decode, status mux, config shadow/apply sequencing,
// rx/tx strobes and edge-triggered interrupt.
module uart_ctrl #(
  parameter logic [15:0] DATA_ADDR    = 16'h0000,
  parameter logic [15:0] STATUS_ADDR  = 16'h0001,
  parameter logic [15:0] CONFIG_ADDR  = 16'h0002,
  parameter logic [3:0]  DEFAULT_BAUD = 4'd11,
  parameter int unsigned CLR_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] port_id,
  input  logic        write_strobe,
  input  logic        read_strobe,
  input  logic [7:0]  out_port,
  output logic [7:0]  in_port,
  output logic        interrupt,
  input  logic        interrupt_ack,
  input  logic [7:0]  rx_data,
  input  logic        RXRDY,
  input  logic        FERR,
  input  logic        PERR,
  input  logic        OVF,
  input  logic        TXRDY,
  input  logic        tx_idle,
  output logic        rx_read,
  output logic        rx_clr,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  output logic        eight,
  output logic        pen,
  output logic        even,
  output logic [3:0]  baud
);

  localparam int unsigned CW = $clog2(CLR_CYCLES + 1);
  localparam logic [6:0] CFG_RESET = {3'b000, DEFAULT_BAUD};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_APPLY,
    S_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      shadow_q, shadow_d;
  logic [6:0]      cfg_q, cfg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            rx_read_q, rx_read_d;
  logic            tx_load_q, tx_load_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            int_q, int_d;
  logic            rxrdy_q, txrdy_q;

  logic            cfg_wr;
  logic            data_wr;
  logic            data_rd;
  logic            cfg_busy;
  logic            rdy_edge;

  assign cfg_wr   = write_strobe && (port_id == CONFIG_ADDR);
  assign data_wr  = write_strobe && (port_id == DATA_ADDR);
  assign data_rd  = read_strobe  && (port_id == DATA_ADDR);
  assign cfg_busy = (state_q != S_IDLE);
  assign rdy_edge = (RXRDY && !rxrdy_q) || (TXRDY && !txrdy_q);

  always_comb begin
    if (port_id == DATA_ADDR)
      in_port = rx_data;
    else if (port_id == STATUS_ADDR)
      in_port = {cfg_busy, 2'b00, TXRDY, OVF, PERR, FERR, RXRDY};
    else
      in_port = '0;
  end

  // A config write landing in APPLY/CLEAR is remembered in pend_q so the
  // clear sequence finishes intact before the new shadow is drained/applied.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    rx_read_d = data_rd;
    tx_load_d = data_wr && (state_q == S_IDLE);
    tx_data_d = tx_data_q;
    int_d     = int_q;

    if (cfg_wr)
      shadow_d = out_port[6:0];

    if (data_wr && (state_q == S_IDLE))
      tx_data_d = out_port;

    if (rdy_edge)
      int_d = 1'b1;
    else if (interrupt_ack)
      int_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_wr)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tx_idle && !tx_load_q)
          state_d = S_APPLY;
      end
      S_APPLY: begin
        cfg_d   = shadow_q;
        cnt_d   = CW'(CLR_CYCLES);
        state_d = S_CLEAR;
        if (cfg_wr)
          pend_d = 1'b1;
      end
      S_CLEAR: begin
        cnt_d = cnt_q - CW'(1);
        if (cfg_wr)
          pend_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          pend_d  = 1'b0;
          state_d = (pend_q || cfg_wr) ? S_DRAIN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= CFG_RESET;
      cfg_q     <= CFG_RESET;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      rx_read_q <= 1'b0;
      tx_load_q <= 1'b0;
      tx_data_q <= '0;
      int_q     <= 1'b0;
      rxrdy_q   <= 1'b0;
      txrdy_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      rx_read_q <= rx_read_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
      int_q     <= int_d;
      rxrdy_q   <= RXRDY;
      txrdy_q   <= TXRDY;
    end
  end

  assign {even, pen, eight, baud} = cfg_q;
  assign rx_clr    = (state_q == S_CLEAR);
  assign rx_read   = rx_read_q;
  assign tx_load   = tx_load_q;
  assign tx_data   = tx_data_q;
  assign interrupt = int_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: read-mux vector table, tx/rx-strobe scoreboard,
// and hand sequences for config sequencing, interrupt and reset corners.
module tb_uart_ctrl;

  localparam logic [15:0] A_DATA   = 16'h0000;
  localparam logic [15:0] A_STATUS = 16'h0001;
  localparam logic [15:0] A_CONFIG = 16'h0002;

  logic        clk;
  logic        rst;
  logic [15:0] port_id;
  logic        write_strobe, read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt, interrupt_ack;
  logic [7:0]  rx_data;
  logic        RXRDY, FERR, PERR, OVF, TXRDY, tx_idle;
  logic        rx_read, rx_clr, tx_load;
  logic [7:0]  tx_data;
  logic        eight, pen, even;
  logic [3:0]  baud;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [7:0] tx_exp_q[$];
  int         tx_cyc_q[$];
  int         rd_cyc_q[$];

  typedef struct {
    logic [15:0] pid;
    logic        rs;
    logic        ws;
    logic [7:0]  wdat;
    logic [7:0]  rxd;
    logic [4:0]  flags;   // {TXRDY, OVF, PERR, FERR, RXRDY}
    logic [7:0]  exp_in;
  } vec_t;

  vec_t tbl[12];

  uart_ctrl #(
    .DATA_ADDR   (A_DATA),
    .STATUS_ADDR (A_STATUS),
    .CONFIG_ADDR (A_CONFIG),
    .DEFAULT_BAUD(4'd11),
    .CLR_CYCLES  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_port      (in_port),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .rx_data      (rx_data),
    .RXRDY        (RXRDY),
    .FERR         (FERR),
    .PERR         (PERR),
    .OVF          (OVF),
    .TXRDY        (TXRDY),
    .tx_idle      (tx_idle),
    .rx_read      (rx_read),
    .rx_clr       (rx_clr),
    .tx_load      (tx_load),
    .tx_data      (tx_data),
    .eight        (eight),
    .pen          (pen),
    .even         (even),
    .baud         (baud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] b);
    port_id      = A_CONFIG;
    out_port     = b;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id      = A_STATUS;
  endtask

  task automatic set_flags(input logic [4:0] f);
    {TXRDY, OVF, PERR, FERR, RXRDY} = f;
  endtask

  // Scoreboard side: registered strobes are popped as the DUT produces them.
  always @(negedge clk) begin
    if (tx_load === 1'b1) begin
      if (tx_exp_q.size() == 0) begin
        chk("tx_load_unexpected", 32'(tx_load), 32'd0);
      end else begin
        chk("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
        chk("tx_load_cycle", 32'(cyc), 32'(tx_cyc_q.pop_front()));
      end
    end
    if (rx_read === 1'b1) begin
      if (rd_cyc_q.size() == 0)
        chk("rx_read_unexpected", 32'(rx_read), 32'd0);
      else
        chk("rx_read_cycle", 32'(cyc), 32'(rd_cyc_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{A_DATA,   1'b1, 1'b0, 8'h00, 8'h5C, 5'b00000, 8'h5C};
    tbl[1]  = '{A_DATA,   1'b0, 1'b1, 8'hA5, 8'hA3, 5'b11111, 8'hA3};
    tbl[2]  = '{A_STATUS, 1'b1, 1'b0, 8'h00, 8'h77, 5'b00001, 8'h01};
    tbl[3]  = '{A_STATUS, 1'b0, 1'b1, 8'h3C, 8'h77, 5'b00010, 8'h02};
    tbl[4]  = '{A_STATUS, 1'b0, 1'b0, 8'h00, 8'h77, 5'b00100, 8'h04};
    tbl[5]  = '{A_STATUS, 1'b0, 1'b0, 8'h00, 8'h77, 5'b01000, 8'h08};
    tbl[6]  = '{A_STATUS, 1'b0, 1'b0, 8'h00, 8'h77, 5'b10000, 8'h10};
    tbl[7]  = '{A_STATUS, 1'b0, 1'b0, 8'h00, 8'h77, 5'b11111, 8'h1F};
    tbl[8]  = '{16'h0003, 1'b1, 1'b0, 8'h00, 8'h77, 5'b11111, 8'h00};
    tbl[9]  = '{A_CONFIG, 1'b0, 1'b0, 8'h00, 8'h77, 5'b11111, 8'h00};
    tbl[10] = '{16'hFFFF, 1'b1, 1'b0, 8'h00, 8'h77, 5'b11111, 8'h00};
    tbl[11] = '{16'h0100, 1'b1, 1'b0, 8'h00, 8'h77, 5'b11111, 8'h00};

    rst = 1'b0; port_id = A_STATUS; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = '0; interrupt_ack = 1'b0; rx_data = '0; tx_idle = 1'b1;
    set_flags(5'b11000);

    // Reset
    repeat (3) tick();
    chk("rst_baud", 32'(baud), 32'd11);
    chk("rst_frame", 32'({eight, pen, even}), 32'd0);
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_status", 32'(in_port), 32'h18);
    chk("rst_pulses", 32'({rx_read, rx_clr, tx_load}), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    set_flags(5'b00000);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("post_rst_interrupt", 32'(interrupt), 32'd0);

    // Read mux / strobe vector table
    for (int unsigned i = 0; i < 12; i++) begin
      port_id      = tbl[i].pid;
      read_strobe  = tbl[i].rs;
      write_strobe = tbl[i].ws;
      out_port     = tbl[i].wdat;
      rx_data      = tbl[i].rxd;
      set_flags(tbl[i].flags);
      if (tbl[i].rs && tbl[i].pid == A_DATA) rd_cyc_q.push_back(cyc + 1);
      if (tbl[i].ws && tbl[i].pid == A_DATA) begin
        tx_exp_q.push_back(tbl[i].wdat);
        tx_cyc_q.push_back(cyc + 1);
      end
      #1;
      chk($sformatf("in_port_vec%0d", i), 32'(in_port), 32'(tbl[i].exp_in));
      tick();
    end
    read_strobe = 1'b0; write_strobe = 1'b0;
    set_flags(5'b00000);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    tick();
    chk("ack_clear", 32'(interrupt), 32'd0);
    chk("status_write_ignored", 32'(baud), 32'd11);

    // Config with tx idle: 0x3A
    port_id = A_STATUS;
    tx_idle = 1'b1;
    cfg_write(8'h3A);
    #1;
    chk("c1_drain_busy", 32'(in_port), 32'h80);
    chk("c1_drain_clr", 32'(rx_clr), 32'd0);
    tick();
    chk("c1_apply_baud_old", 32'(baud), 32'd11);
    chk("c1_apply_clr", 32'(rx_clr), 32'd0);
    tick();
    chk("c1_cfg", 32'({even, pen, eight, baud}), 32'({1'b0, 1'b1, 1'b1, 4'hA}));
    chk("c1_clr_1", 32'(rx_clr), 32'd1);
    chk("c1_busy_clear", 32'(in_port[7]), 32'd1);
    tick();
    chk("c1_clr_2", 32'(rx_clr), 32'd1);
    tick();
    chk("c1_clr_end", 32'(rx_clr), 32'd0);
    chk("c1_idle", 32'(in_port), 32'h00);

    // Config while tx busy: 0x05 then 0x47, tx write dropped in DRAIN
    tx_idle = 1'b0;
    cfg_write(8'h05);
    cfg_write(8'h47);
    port_id = A_DATA; out_port = 8'h99; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0; port_id = A_STATUS;
    repeat (3) tick();
    chk("c2_hold_baud", 32'(baud), 32'hA);
    chk("c2_hold_busy", 32'(in_port), 32'h80);
    tx_idle = 1'b1;
    tick();
    chk("c2_apply_baud_old", 32'(baud), 32'hA);
    tick();
    chk("c2_cfg", 32'({even, pen, eight, baud}), 32'({1'b1, 1'b0, 1'b0, 4'h7}));
    repeat (2) tick();
    chk("c2_idle", 32'(in_port), 32'h00);

    // Config write during CLEAR re-enters DRAIN afterwards
    cfg_write(8'h12);
    repeat (2) tick();
    chk("c3_cfg_a", 32'({even, pen, eight, baud}), 32'({1'b0, 1'b0, 1'b1, 4'h2}));
    cfg_write(8'h3B);
    chk("c3_clr_still", 32'(rx_clr), 32'd1);
    tick();
    chk("c3_redrain_clr", 32'(rx_clr), 32'd0);
    chk("c3_redrain_busy", 32'(in_port), 32'h80);
    chk("c3_redrain_baud", 32'(baud), 32'h2);
    repeat (2) tick();
    chk("c3_cfg_b", 32'({even, pen, eight, baud}), 32'({1'b0, 1'b1, 1'b1, 4'hB}));
    repeat (2) tick();
    chk("c3_idle", 32'(in_port), 32'h00);

    // Rx read strobe: exactly one cycle
    RXRDY = 1'b1; rx_data = 8'h5C; port_id = A_DATA; read_strobe = 1'b1;
    rd_cyc_q.push_back(cyc + 1);
    #1;
    chk("rd_in_port", 32'(in_port), 32'h5C);
    tick();
    read_strobe = 1'b0;
    chk("rd_pulse", 32'(rx_read), 32'd1);
    tick();
    chk("rd_pulse_end", 32'(rx_read), 32'd0);

    // Tx write in IDLE
    out_port = 8'hA5; write_strobe = 1'b1;
    tx_exp_q.push_back(8'hA5);
    tx_cyc_q.push_back(cyc + 1);
    tick();
    write_strobe = 1'b0;
    chk("tx_pulse", 32'({tx_load, tx_data}), 32'({1'b1, 8'hA5}));
    tick();
    chk("tx_pulse_end", 32'(tx_load), 32'd0);

    // Interrupt edges and ack priority
    set_flags(5'b00000);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    tick();
    chk("irq_idle", 32'(interrupt), 32'd0);
    RXRDY = 1'b1;
    #1;
    chk("irq_not_yet", 32'(interrupt), 32'd0);
    tick();
    chk("irq_rx_edge", 32'(interrupt), 32'd1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("irq_ack", 32'(interrupt), 32'd0);
    tick();
    chk("irq_level_no_edge", 32'(interrupt), 32'd0);
    TXRDY = 1'b1; interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("irq_set_wins", 32'(interrupt), 32'd1);
    tick();
    chk("irq_held", 32'(interrupt), 32'd1);
    set_flags(5'b00000);

    // Reset mid-DRAIN discards shadow
    tx_idle = 1'b0;
    port_id = A_STATUS;
    cfg_write(8'h25);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tx_idle = 1'b1;
    chk("rst_drain_idle", 32'(in_port), 32'h00);
    chk("rst_drain_irq", 32'(interrupt), 32'd0);
    repeat (4) tick();
    chk("rst_drain_baud", 32'({even, pen, eight, baud}), 32'({3'b000, 4'd11}));

    // Reset mid-CLEAR drops rx_clr at once
    cfg_write(8'h13);
    repeat (2) tick();
    chk("rst_clear_pre", 32'(rx_clr), 32'd1);
    rst = 1'b0;
    tick();
    chk("rst_clear_clr", 32'(rx_clr), 32'd0);
    chk("rst_clear_idle", 32'(in_port), 32'h00);
    chk("rst_clear_baud", 32'(baud), 32'd11);
    rst = 1'b1;
    repeat (3) tick();

    chk("tx_sb_empty", 32'(tx_exp_q.size()), 32'd0);
    chk("rd_sb_empty", 32'(rd_cyc_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
